// File: rtl/stopwatch_bcd_pkg.sv
// Shared constants for the BCD stopwatch: digit width and limits, FSM state
// encoding and the bit offsets of each digit on the 20-bit display bus.
package stopwatch_bcd_pkg;

  localparam int unsigned DIGIT_W = 4;

  // Largest value each digit may hold before rolling over
  localparam logic [DIGIT_W-1:0] MAX_9 = 4'd9;
  localparam logic [DIGIT_W-1:0] MAX_5 = 4'd5;

  // FSM encoding kept as plain constants for compatibility with older tools
  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StRun   = 2'd1;
  localparam state_t StLap   = 2'd2;
  localparam state_t StPause = 2'd3;

  // Display bus layout: {min, sec_t, sec_u, tenth, hund}
  localparam int unsigned HUND_LSB  = 0;
  localparam int unsigned TENTH_LSB = 4;
  localparam int unsigned SEC_U_LSB = 8;
  localparam int unsigned SEC_T_LSB = 12;
  localparam int unsigned MIN_LSB   = 16;
  localparam int unsigned DISP_W    = 20;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD digit of the stopwatch counter chain.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   clr        : synchronous zero (higher priority than inc)
//   inc        : incoming carry; advance by one when high
//   q          : current digit value
//   carry      : inc & (q == MAX), feeds the next digit up
module bcd_digit
  import stopwatch_bcd_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  logic [DIGIT_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = (q_q == MAX) ? '0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = inc & (q_q == MAX);

endmodule

// File: rtl/stopwatch_bcd.sv
// Stopwatch core: divides the 1 ms strobe to a 10 ms tick and counts M:SS.hh
// in BCD, with start/stop, lap (display freeze) and clear controls.
// Ports:
//   clk, rst_n  : clock and synchronous active-low reset
//   ce1ms       : 1 ms clock-enable strobe
//   start_stop  : run/pause toggle pulse
//   lap         : freeze/unfreeze display pulse
//   clear       : zero-count pulse (acts only while paused)
//   disp        : {min, sec_t, sec_u, tenth, hund} BCD, lap value while frozen
//   running     : high in RUN and LAP
//   lap_active  : high in LAP
//   overflow    : set when 9:59.99 wraps to 0:00.00
module stopwatch_bcd
  import stopwatch_bcd_pkg::*;
#(
  parameter int unsigned MS_PER_TICK = 10,
  parameter bit          WRAP_STICKY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce1ms,
  input  logic              start_stop,
  input  logic              lap,
  input  logic              clear,
  output logic [DISP_W-1:0] disp,
  output logic              running,
  output logic              lap_active,
  output logic              overflow
);

  localparam int unsigned PW = (MS_PER_TICK > 1) ? $clog2(MS_PER_TICK) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(MS_PER_TICK - 1);

  state_t            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [DISP_W-1:0] lap_q, lap_d;
  logic              ovf_q, ovf_d;

  logic              clr_win, ss_win, lap_win;
  logic              counting, tick, zero;
  logic [DISP_W-1:0] live;

  logic [DIGIT_W-1:0] hund, tenth, sec_u, sec_t, mins;
  logic               c_hund, c_tenth, c_sec_u, c_sec_t, c_min;

  // Only the highest-priority pulse is seen by the FSM
  assign clr_win = clear;
  assign ss_win  = start_stop & ~clear;
  assign lap_win = lap & ~start_stop & ~clear;

  // Ticks use the pre-edge state, so a stop coinciding with a tick still counts
  assign counting = (state_q == StRun) || (state_q == StLap);
  assign tick     = counting & ce1ms & (presc_q == PRESC_MAX);
  assign zero     = (state_q == StPause) & clr_win;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ss_win) state_d = StRun;
      StRun: begin
        if (ss_win)       state_d = StPause;
        else if (lap_win) state_d = StLap;
      end
      StLap: begin
        if (ss_win)       state_d = StPause;
        else if (lap_win) state_d = StRun;
      end
      StPause: begin
        if (ss_win)       state_d = StRun;
        else if (clr_win) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    presc_d = presc_q;
    if (zero) begin
      presc_d = '0;
    end else if (counting && ce1ms) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
  end

  always_comb begin
    lap_d = lap_q;
    if (zero) begin
      lap_d = '0;
    end else if ((state_q == StRun) && lap_win) begin
      lap_d = live;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (WRAP_STICKY) begin
      if (zero)       ovf_d = 1'b0;
      else if (c_min) ovf_d = 1'b1;
    end else begin
      ovf_d = c_min;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      presc_q <= '0;
      lap_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      lap_q   <= lap_d;
      ovf_q   <= ovf_d;
    end
  end

  bcd_digit #(.MAX(MAX_9)) u_hund (
    .clk(clk), .rst_n(rst_n), .clr(zero), .inc(tick), .q(hund), .carry(c_hund)
  );
  bcd_digit #(.MAX(MAX_9)) u_tenth (
    .clk(clk), .rst_n(rst_n), .clr(zero), .inc(c_hund), .q(tenth), .carry(c_tenth)
  );
  bcd_digit #(.MAX(MAX_9)) u_sec_u (
    .clk(clk), .rst_n(rst_n), .clr(zero), .inc(c_tenth), .q(sec_u), .carry(c_sec_u)
  );
  bcd_digit #(.MAX(MAX_5)) u_sec_t (
    .clk(clk), .rst_n(rst_n), .clr(zero), .inc(c_sec_u), .q(sec_t), .carry(c_sec_t)
  );
  bcd_digit #(.MAX(MAX_9)) u_min (
    .clk(clk), .rst_n(rst_n), .clr(zero), .inc(c_sec_t), .q(mins), .carry(c_min)
  );

  always_comb begin
    live = '0;
    live[HUND_LSB  +: DIGIT_W] = hund;
    live[TENTH_LSB +: DIGIT_W] = tenth;
    live[SEC_U_LSB +: DIGIT_W] = sec_u;
    live[SEC_T_LSB +: DIGIT_W] = sec_t;
    live[MIN_LSB   +: DIGIT_W] = mins;
  end

  assign running    = counting;
  assign lap_active = (state_q == StLap);
  assign disp       = lap_active ? lap_q : live;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
module tb_stopwatch_bcd;

  logic        clk;
  logic        rst_n;
  logic        ce1ms;
  logic        start_stop;
  logic        lap;
  logic        clear;
  logic [19:0] disp;
  logic        running;
  logic        lap_active;
  logic        overflow;

  int n_pass  = 0;
  int n_total = 0;

  stopwatch_bcd #(
    .MS_PER_TICK(10),
    .WRAP_STICKY(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce1ms     (ce1ms),
    .start_stop(start_stop),
    .lap       (lap),
    .clear     (clear),
    .disp      (disp),
    .running   (running),
    .lap_active(lap_active),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs at negedge; returns at the following negedge
  task automatic pulse(input logic ce, input logic ss, input logic lp, input logic cl);
    @(negedge clk);
    ce1ms = ce; start_stop = ss; lap = lp; clear = cl;
    @(negedge clk);
    ce1ms = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; ce1ms = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_disp", {12'd0, disp}, 32'h0);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_lap_active", {31'd0, lap_active}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;

    // ce1ms while idle does nothing
    strobes(20);
    check("idle_ce_disp", {12'd0, disp}, 32'h0);

    // First hundredth after 10 strobes
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    strobes(9);
    check("ten_pre", {12'd0, disp}, 32'h0);
    strobes(1);
    check("ten_disp", {12'd0, disp}, 32'h00001);
    check("ten_running", {31'd0, running}, 32'd1);
    // clear ignored while running
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("run_clear_ignored", {12'd0, disp}, 32'h00001);
    check("run_clear_running", {31'd0, running}, 32'd1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("clr1_disp", {12'd0, disp}, 32'h0);

    // One second, then pause holds
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    strobes(1000);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    strobes(50);
    check("pause_disp", {12'd0, disp}, 32'h00100);
    check("pause_running", {31'd0, running}, 32'd0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("clr2_disp", {12'd0, disp}, 32'h0);
    check("clr2_running", {31'd0, running}, 32'd0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("idle_restart_running", {31'd0, running}, 32'd1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);

    // Lap freeze
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    strobes(1230);
    check("lap_pre", {12'd0, disp}, 32'h00123);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    strobes(200);
    check("lap_frozen", {12'd0, disp}, 32'h00123);
    check("lap_active", {31'd0, lap_active}, 32'd1);
    check("lap_running", {31'd0, running}, 32'd1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("lap_release", {12'd0, disp}, 32'h00143);
    check("lap_released_flag", {31'd0, lap_active}, 32'd0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);

    // Partial interval survives pause
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    strobes(4);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    strobes(5);
    check("resume_5", {12'd0, disp}, 32'h0);
    strobes(1);
    check("resume_6", {12'd0, disp}, 32'h00001);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);

    // Wrap: preload 9:59.99 while paused, then one tick
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    force dut.u_hund.q_q  = 4'd9;
    force dut.u_tenth.q_q = 4'd9;
    force dut.u_sec_u.q_q = 4'd9;
    force dut.u_sec_t.q_q = 4'd5;
    force dut.u_min.q_q   = 4'd9;
    @(negedge clk);
    release dut.u_hund.q_q;
    release dut.u_tenth.q_q;
    release dut.u_sec_u.q_q;
    release dut.u_sec_t.q_q;
    release dut.u_min.q_q;
    @(negedge clk);
    check("preload", {12'd0, disp}, 32'h95999);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    strobes(9);
    check("wrap_pre_disp", {12'd0, disp}, 32'h95999);
    check("wrap_pre_ovf", {31'd0, overflow}, 32'd0);
    strobes(1);
    check("wrap_disp", {12'd0, disp}, 32'h0);
    check("wrap_ovf", {31'd0, overflow}, 32'd1);
    strobes(1000);
    check("wrap_sticky_disp", {12'd0, disp}, 32'h00100);
    check("wrap_sticky_ovf", {31'd0, overflow}, 32'd1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("wrap_pause_ovf", {31'd0, overflow}, 32'd1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("wrap_clr_ovf", {31'd0, overflow}, 32'd0);
    check("wrap_clr_disp", {12'd0, disp}, 32'h0);

    // Coincident pulses
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    strobes(30);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("co_pre", {12'd0, disp}, 32'h00003);
    pulse(1'b0, 1'b1, 1'b1, 1'b1);
    check("co_all_disp", {12'd0, disp}, 32'h0);
    check("co_all_running", {31'd0, running}, 32'd0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    check("co_sslap_lap", {31'd0, lap_active}, 32'd0);
    check("co_sslap_running", {31'd0, running}, 32'd0);

    // Stop on the tick edge still counts that tick
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    strobes(9);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    check("stop_tick_disp", {12'd0, disp}, 32'h00001);
    check("stop_tick_running", {31'd0, running}, 32'd0);
    strobes(10);
    check("stop_tick_held", {12'd0, disp}, 32'h00001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
